// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and types for the byte display scanner
package disp_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIG_DATA_LO = 2'd0;
    localparam digit_idx_t DIG_DATA_HI = 2'd1;
    localparam digit_idx_t DIG_CNT_LO  = 2'd2;
    localparam digit_idx_t DIG_CNT_HI  = 2'd3;

    // Active-high {g,f,e,d,c,b,a} codes for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [3:0] digit_enable(digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/byte_display_scan_if.sv
// rtl/byte_display_scan_if.sv - capture inputs and display outputs of the scanner
interface byte_display_scan_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       clr;
    logic       hold;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (
        output data_in, data_valid, clr, hold,
        input  seg, dp, an
    );

    modport slave (
        input  data_in, data_valid, clr, hold,
        output seg, dp, an
    );
endinterface

// File: rtl/hex_to_sseg.sv
// rtl/hex_to_sseg.sv - nibble to active-high seven-segment code
module hex_to_sseg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);
    assign code = HEX_SEG[nibble];
endmodule

// File: rtl/byte_display_scan.sv
// rtl/byte_display_scan.sv - captures a byte and count, scans them onto a 4-digit display
module byte_display_scan
    import disp_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    byte_display_scan_if.slave  bus
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

    logic [7:0]    data_reg;
    logic [7:0]    cnt;
    logic [PW-1:0] prescaler;
    digit_idx_t    digit_idx;
    logic [3:0]    nibble;
    logic [6:0]    code;
    logic          dp_lit;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    // clr outranks capture so a strobe in the clear cycle is dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_reg <= 8'd0;
            cnt      <= 8'd0;
        end else if (bus.clr) begin
            data_reg <= 8'd0;
            cnt      <= 8'd0;
        end else if (bus.data_valid && !bus.hold) begin
            data_reg <= bus.data_in;
            cnt      <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prescaler <= '0;
            digit_idx <= DIG_DATA_LO;
        end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_comb begin
        nibble = data_reg[3:0];
        unique case (digit_idx)
            DIG_DATA_LO: nibble = data_reg[3:0];
            DIG_DATA_HI: nibble = data_reg[7:4];
            DIG_CNT_LO:  nibble = cnt[3:0];
            DIG_CNT_HI:  nibble = cnt[7:4];
        endcase
    end

    hex_to_sseg u_hex (
        .nibble (nibble),
        .code   (code)
    );

    assign dp_lit = (digit_idx == DIG_CNT_LO) && bus.hold;

    // Output stage is registered so an/seg/dp switch together on one edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            an_q  <= digit_enable(DIG_DATA_LO);
            seg_q <= HEX_SEG[0] ^ {7{SEG_ACTIVE_LOW}};
            dp_q  <= SEG_ACTIVE_LOW;
        end else begin
            an_q  <= digit_enable(digit_idx);
            seg_q <= code ^ {7{SEG_ACTIVE_LOW}};
            dp_q  <= dp_lit ^ SEG_ACTIVE_LOW;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: doc/byte_display_scan.md
Name: byte_display_scan

Overview:
- Downstream consumer of the top-level 8-bit `out` bus; drives the board's 4-digit multiplexed seven-segment display.
- Captures a byte on a valid strobe and keeps an 8-bit capture counter.
- Shows the byte as hex on digits 1:0 and the capture count as hex on digits 3:2.
- Scans the digits with a prescaled counter.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays enabled; minimum 2; benches use 4.
- SEG_ACTIVE_LOW, 1, 1 = `seg` and `dp` are driven active-low; 0 = active-high.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous reset, active-low: 0 at a rising clk edge resets.
- data_in  input  8  byte from the upstream message block.
- data_valid  input  1  single-cycle strobe qualifying data_in.
- clr  input  1  synchronous clear of the captured byte and the count.
- hold  input  1  freezes capture while 1.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- dp  output  1  decimal point.
- an  output  4  digit enables, always active-low one-hot.

Behaviour:
- Priority at each edge: rst==0, then clr, then capture.
- Reset, rst==0 at an edge:
  - data_reg=0, cnt=0, prescaler=0, digit_idx=0.
  - an=4'b1110; seg=encoding of 0 (7'h3F, inverted when SEG_ACTIVE_LOW); dp off.
- Capture, when data_valid && !hold && !clr:
  - data_reg<=data_in.
  - cnt<=cnt+1, modulo 256; 255 wraps to 0.
- hold==1: data_valid is ignored, with no capture and no count.
- clr==1: data_reg<=0 and cnt<=0. Any data_valid in the same cycle is dropped.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - When prescaler==SCAN_DIV-1, digit_idx advances 0→1→2→3→0.
  - The prescaler is not affected by clr, hold or data_valid.
- Digit nibble selection:
  - idx0 = data_reg[3:0]
  - idx1 = data_reg[7:4]
  - idx2 = cnt[3:0]
  - idx3 = cnt[7:4]
- Outputs are registered:
  - an, seg and dp reflect digit_idx and the register contents from the previous edge, giving 1-cycle latency.
  - an[k]=0 exactly when the registered idx==k; there is no all-off or multi-on state.
- Hex encoding, active-high gfedcba:
  - 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07
  - 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71
  - seg = SEG_ACTIVE_LOW ? ~code : code.
- dp is lit only while digit 2 is enabled and hold==1. It separates count from data and flags hold.
- A capture during a digit's slot updates that digit's seg one cycle later; there is no glitch on an.
- Reset mid-scan: the display restarts at digit 0 and the prescaler at 0 on the next edge.

Decomposition:
- Shared package `disp_pkg`:
  - HEX_SEG constant array (16×7, values above).
  - Digit-index typedef, 2 bits.
  - DIG_DATA_LO=0, DIG_DATA_HI=1, DIG_CNT_LO=2, DIG_CNT_HI=3.
- Sub-module `hex_to_sseg`: 4-bit nibble to 7-bit active-high code, purely combinational, reusable.
- Polarity inversion and registering stay in byte_display_scan.

Test Plan (SCAN_DIV=4, SEG_ACTIVE_LOW=1):
1. Hold rst=0 for 2 edges, then rst=1 → an=1110, seg=~7'h3F=7'h40, dp=1 (off). an steps 1101, 1011, 0111, 1110 every 4 cycles.
2. data_in=8'hA5, data_valid pulse → data digits show A (~77=08) on an=1101 and 5 (~6D=12) on an=1110. Count digits show 1 (~06=79) and 0.
3. 256 data_valid pulses from reset → cnt wraps to 0 and both count digits read 0. A 257th pulse makes cnt=1.
4. clr=1 with data_valid=1 and data_in=8'hFF in the same cycle → data_reg=0 and cnt=0; the byte is not captured.
5. hold=1, data_in=8'h3C, data_valid pulse → data_reg and cnt unchanged. dp=0 (lit) only while an=1011.
6. Drive rst=0 mid-scan while an=0111 → on the next edge an=1110 and prescaler=0. The first advance happens 4 cycles after rst returns to 1.
